tlb_refill_ctrl: RTL and testbench

Refill and configuration controller for the 8-entry fully associative TLB. Owns the 8 PTE registers and drives the TLB's flat initialization vector. Accepts miss requests from the fetch port and the data (RR/DEC) port, arbitrates between them, and walks a linear page table through a req/ack memory handshake. Fills the selected entry, or reports a page fault when the returned PTE is not present or not valid.

---
 rtl/tlb_refill_ctrl_if.sv | 45 ++++
 rtl/tlb_refill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tlb_refill_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_refill_ctrl_if.sv
// Signal bundle between tlb_refill_ctrl and its requesters, page-table memory and OS init path.
// Walk/fault counters exist only when TLB_REFILL_STATS_EN is defined.
interface tlb_refill_ctrl_if #(
    parameter int PTE_WIDTH = 44
);
    logic                   i_fetch_miss;
    logic [31:0]            i_fetch_va;
    logic                   i_tlb_miss;
    logic [31:0]            i_tlb_va;
    logic                   o_fetch_done;
    logic                   o_tlb_done;
    logic                   o_fault;
    logic                   o_mem_req;
    logic [31:0]            o_mem_addr;
    logic                   i_mem_ack;
    logic [PTE_WIDTH-1:0]   i_mem_pte;
    logic                   i_init_vld;
    logic [2:0]             i_init_idx;
    logic [PTE_WIDTH-1:0]   i_init_pte;
    logic                   i_flush;
    logic                   o_busy;
    logic [PTE_WIDTH*8-1:0] o_tlb_reg;
`ifdef TLB_REFILL_STATS_EN
    logic [15:0]            o_walk_cnt;
    logic [15:0]            o_fault_cnt;
`endif

    modport slave (
        input  i_fetch_miss, i_fetch_va, i_tlb_miss, i_tlb_va,
        input  i_mem_ack, i_mem_pte, i_init_vld, i_init_idx, i_init_pte, i_flush,
`ifdef TLB_REFILL_STATS_EN
        output o_walk_cnt, o_fault_cnt,
`endif
        output o_fetch_done, o_tlb_done, o_fault, o_mem_req, o_mem_addr, o_busy, o_tlb_reg
    );

    modport master (
        output i_fetch_miss, i_fetch_va, i_tlb_miss, i_tlb_va,
        output i_mem_ack, i_mem_pte, i_init_vld, i_init_idx, i_init_pte, i_flush,
`ifdef TLB_REFILL_STATS_EN
        input  o_walk_cnt, o_fault_cnt,
`endif
        input  o_fetch_done, o_tlb_done, o_fault, o_mem_req, o_mem_addr, o_busy, o_tlb_reg
    );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// Refill/config controller for the 8-entry fully associative TLB: arbitrates fetch/data misses,
// walks a linear page table, fills or faults. Define TLB_REFILL_STATS_EN for walk/fault counters.
module tlb_refill_ctrl #(
    parameter int          PTE_WIDTH = 44,
    parameter logic [31:0] PT_BASE   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    tlb_refill_ctrl_if.slave bus
);
    localparam int PRES_B  = 1;
    localparam int VAL_B   = 2;
    localparam int VPN_LSB = 23;
    localparam int VPN_MSB = 42;

    typedef enum logic [1:0] {IDLE, WALK, FILL, RESP} state_t;

    state_t                    state_q;
    logic [7:0][PTE_WIDTH-1:0] ent_q;
    logic [PTE_WIDTH-1:0]      pte_q;
    logic [2:0]                ptr_q;
    logic                      last_fetch_q;
    logic                      req_fetch_q;
    logic                      mem_req_q;
    logic [31:0]               mem_addr_q;
    logic                      fetch_done_q;
    logic                      tlb_done_q;
    logic                      fault_q;
    logic                      flush_pend_q;
    logic                      init_pend_q;
    logic [2:0]                init_idx_q;
    logic [PTE_WIDTH-1:0]      init_pte_q;

    logic [19:0] fetch_vpn, data_vpn, fill_vpn, grant_vpn;
    logic        fetch_hit, data_hit, same_found, inv_found;
    logic [2:0]  same_idx, inv_idx, fill_idx, ptr_d;
    logic        fetch_elig, data_elig, grant_fetch;
    logic        do_flush, do_init, accept, pte_ok, use_ptr;
    logic        unused_va;

    assign fetch_vpn = bus.i_fetch_va[31:12];
    assign data_vpn  = bus.i_tlb_va[31:12];
    assign fill_vpn  = pte_q[VPN_MSB:VPN_LSB];
    assign unused_va = ^{bus.i_fetch_va[11:0], bus.i_tlb_va[11:0]};

    // Lookup and victim search; descending scan so the lowest index wins.
    always_comb begin
        fetch_hit  = 1'b0;
        data_hit   = 1'b0;
        same_found = 1'b0;
        inv_found  = 1'b0;
        same_idx   = 3'd0;
        inv_idx    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ent_q[i][VAL_B] && ent_q[i][PRES_B]) begin
                if (ent_q[i][VPN_MSB:VPN_LSB] == fetch_vpn) fetch_hit = 1'b1;
                if (ent_q[i][VPN_MSB:VPN_LSB] == data_vpn)  data_hit  = 1'b1;
            end
            if (ent_q[i][VAL_B] && (ent_q[i][VPN_MSB:VPN_LSB] == fill_vpn)) begin
                same_found = 1'b1;
                same_idx   = 3'(i);
            end
            if (!ent_q[i][VAL_B]) begin
                inv_found = 1'b1;
                inv_idx   = 3'(i);
            end
        end
    end

    // A miss whose VPN is already resident is stale and never starts a walk.
    assign fetch_elig  = bus.i_fetch_miss && !fetch_hit;
    assign data_elig   = bus.i_tlb_miss && !data_hit;
    assign grant_fetch = fetch_elig && (!data_elig || !last_fetch_q);
    assign grant_vpn   = grant_fetch ? fetch_vpn : data_vpn;
    assign do_flush    = bus.i_flush || flush_pend_q;
    assign do_init     = bus.i_init_vld || init_pend_q;
    assign accept      = (fetch_elig || data_elig) && !do_flush && !do_init;
    assign pte_ok      = pte_q[VAL_B] && pte_q[PRES_B];
    assign use_ptr     = !same_found && !inv_found;
    assign fill_idx    = same_found ? same_idx : (inv_found ? inv_idx : ptr_q);
    assign ptr_d       = ptr_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ent_q        <= '0;
            pte_q        <= '0;
            ptr_q        <= 3'd0;
            last_fetch_q <= 1'b1;   // pretend fetch went last so data wins the first contest
            req_fetch_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            fetch_done_q <= 1'b0;
            tlb_done_q   <= 1'b0;
            fault_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            init_pend_q  <= 1'b0;
            init_idx_q   <= 3'd0;
            init_pte_q   <= '0;
        end else begin
            fetch_done_q <= 1'b0;
            tlb_done_q   <= 1'b0;
            fault_q      <= 1'b0;

            // Config writes arriving mid-walk are parked; only the latest init is kept.
            if (state_q != IDLE) begin
                if (bus.i_flush) flush_pend_q <= 1'b1;
                if (bus.i_init_vld) begin
                    init_pend_q <= 1'b1;
                    init_idx_q  <= bus.i_init_idx;
                    init_pte_q  <= bus.i_init_pte;
                end
            end

            case (state_q)
                IDLE: begin
                    if (do_flush) begin
                        for (int i = 0; i < 8; i++) ent_q[i][VAL_B] <= 1'b0;
                        ptr_q        <= 3'd0;
                        flush_pend_q <= 1'b0;
                    end
                    // Full-entry writes after the flush so init overrides the cleared valid bit.
                    if (init_pend_q) begin
                        ent_q[init_idx_q] <= init_pte_q;
                        init_pend_q       <= 1'b0;
                    end
                    if (bus.i_init_vld) ent_q[bus.i_init_idx] <= bus.i_init_pte;
                    if (accept) begin
                        req_fetch_q  <= grant_fetch;
                        last_fetch_q <= grant_fetch;
                        mem_addr_q   <= PT_BASE + {9'd0, grant_vpn, 3'b000};
                        mem_req_q    <= 1'b1;
                        state_q      <= WALK;
                    end
                end
                WALK: begin
                    if (bus.i_mem_ack) begin
                        pte_q     <= bus.i_mem_pte;
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (pte_ok) begin
                        ent_q[fill_idx] <= pte_q;
                        if (use_ptr) ptr_q <= ptr_d;
                    end else begin
                        fault_q <= 1'b1;
                    end
                    fetch_done_q <= req_fetch_q;
                    tlb_done_q   <= !req_fetch_q;
                    state_q      <= RESP;
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_tlb_reg    = ent_q;
    assign bus.o_mem_req    = mem_req_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_fetch_done = fetch_done_q;
    assign bus.o_tlb_done   = tlb_done_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_busy       = (state_q != IDLE);

`ifdef TLB_REFILL_STATS_EN
    logic [15:0] walk_cnt_q;
    logic [15:0] fault_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_cnt_q  <= 16'd0;
            fault_cnt_q <= 16'd0;
        end else begin
            if ((state_q == IDLE) && accept && (walk_cnt_q != 16'hFFFF))
                walk_cnt_q <= walk_cnt_q + 16'd1;
            if ((state_q == FILL) && !pte_ok && (fault_cnt_q != 16'hFFFF))
                fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign bus.o_walk_cnt  = walk_cnt_q;
    assign bus.o_fault_cnt = fault_cnt_q;
`endif
endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: table of single-miss walks plus hand sequences for
// contention, flush/fill ordering and reset mid-walk. Driven and sampled on the falling edge.
module tb_tlb_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tlb_refill_ctrl_if #(.PTE_WIDTH(44)) bus();

    tlb_refill_ctrl #(.PTE_WIDTH(44), .PT_BASE(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          fetch;
        logic [31:0] va;
        logic [43:0] pte;
        int          dly;
        bit          fault;
        int          idx;
        logic [31:0] addr;
    } vec_t;

    vec_t             tbl [6];
    logic [7:0][43:0] mdl;
    int               n_chk = 0;
    int               n_fail = 0;

    function automatic logic [43:0] mk_pte(input logic c, input logic [19:0] vpn,
                                           input logic [19:0] ppn, input logic v,
                                           input logic p, input logic rw);
        return {c, vpn, ppn, v, p, rw};
    endfunction

    task automatic chk(input string nm, input logic [351:0] act, input logic [351:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_valid();
        for (int i = 0; i < 8; i++) mdl[i][2] = 1'b0;
    endtask

    // One complete walk for a single requester; caller sits on a falling edge in IDLE.
    task automatic do_miss(input bit fetch, input logic [31:0] va, input logic [43:0] pte,
                           input int dly, input bit efault, input int eidx,
                           input logic [31:0] eaddr, input string nm);
        if (fetch) begin bus.i_fetch_miss = 1'b1; bus.i_fetch_va = va; end
        else       begin bus.i_tlb_miss   = 1'b1; bus.i_tlb_va   = va; end
        @(negedge clk);
        chk({nm, " mem_req"}, bus.o_mem_req, 1);
        chk({nm, " mem_addr"}, bus.o_mem_addr, eaddr);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk({nm, " mem_req held"}, bus.o_mem_req, 1);
        end
        bus.i_mem_pte = pte;
        bus.i_mem_ack = 1'b1;
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
        chk({nm, " req drop"}, {bus.o_mem_req, bus.o_fetch_done, bus.o_tlb_done}, 0);
        @(negedge clk);
        chk({nm, " done"}, {bus.o_fetch_done, bus.o_tlb_done}, {fetch, !fetch});
        chk({nm, " fault"}, bus.o_fault, efault);
        if (!efault) mdl[eidx] = pte;
        chk({nm, " entries"}, bus.o_tlb_reg, mdl);
        bus.i_fetch_miss = 1'b0;
        bus.i_tlb_miss   = 1'b0;
        @(negedge clk);
        chk({nm, " idle"}, {bus.o_busy, bus.o_fetch_done, bus.o_tlb_done, bus.o_fault}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [19:0] vpn;
        logic [43:0] p, x;

        tbl[0] = '{1'b1, 32'h0000_9000, mk_pte(0, 20'h9,  20'h3, 1, 1, 0), 0, 1'b0, 0, 32'h48};
        tbl[1] = '{1'b0, 32'h0000_A123, mk_pte(0, 20'hA,  20'h4, 1, 0, 0), 2, 1'b1, 0, 32'h50};
        tbl[2] = '{1'b1, 32'h0000_B000, mk_pte(0, 20'hB,  20'h5, 1, 1, 1), 1, 1'b0, 1, 32'h58};
        tbl[3] = '{1'b0, 32'h0000_C000, mk_pte(0, 20'hC,  20'h6, 0, 1, 0), 0, 1'b1, 0, 32'h60};
        tbl[4] = '{1'b1, 32'h0005_5000, mk_pte(0, 20'h55, 20'h8, 1, 1, 0), 3, 1'b0, 5, 32'h2A8};
        tbl[5] = '{1'b0, 32'h000D_0FFF, mk_pte(1, 20'hD0, 20'h9, 1, 1, 1), 0, 1'b0, 2, 32'h680};

        rst_n = 1'b0;
        bus.i_fetch_miss = 0; bus.i_fetch_va = 0; bus.i_tlb_miss = 0; bus.i_tlb_va = 0;
        bus.i_mem_ack = 0; bus.i_mem_pte = 0; bus.i_init_vld = 0; bus.i_init_idx = 0;
        bus.i_init_pte = 0; bus.i_flush = 0;
        mdl = '0;
        repeat (2) @(negedge clk);
        chk("reset entries", bus.o_tlb_reg, 0);
        chk("reset outputs", {bus.o_mem_req, bus.o_busy, bus.o_fetch_done, bus.o_tlb_done, bus.o_fault}, 0);
        chk("reset mem_addr", bus.o_mem_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous misses straight out of reset: data first, then fetch.
        bus.i_fetch_miss = 1; bus.i_fetch_va = 32'h0000_5000;
        bus.i_tlb_miss   = 1; bus.i_tlb_va   = 32'h0000_6000;
        @(negedge clk);
        chk("rr1 mem_addr", bus.o_mem_addr, 32'h30);
        p = mk_pte(0, 20'h6, 20'h16, 1, 1, 0);
        bus.i_mem_pte = p; bus.i_mem_ack = 1;
        @(negedge clk);
        bus.i_mem_ack = 0;
        @(negedge clk);
        chk("rr1 done", {bus.o_tlb_done, bus.o_fetch_done}, 2'b10);
        mdl[0] = p;
        bus.i_tlb_miss = 0;
        @(negedge clk);
        chk("rr gap idle", {bus.o_busy, bus.o_mem_req}, 0);
        @(negedge clk);
        chk("rr2 mem_addr", {bus.o_mem_req, bus.o_mem_addr}, {1'b1, 32'h28});
        p = mk_pte(0, 20'h5, 20'h15, 1, 1, 0);
        bus.i_mem_pte = p; bus.i_mem_ack = 1;
        @(negedge clk);
        bus.i_mem_ack = 0;
        @(negedge clk);
        chk("rr2 done", {bus.o_tlb_done, bus.o_fetch_done}, 2'b01);
        mdl[1] = p;
        chk("rr entries", bus.o_tlb_reg, mdl);
        bus.i_fetch_miss = 0;
        @(negedge clk);

        // OS init of all entries, then entry 5 valid but not present.
        for (int i = 0; i < 8; i++) begin
            bus.i_init_vld = 1; bus.i_init_idx = 3'(i);
            bus.i_init_pte = mk_pte(0, 20'(i), 20'(32'h100 + i), 1, 1, 0);
            mdl[i] = bus.i_init_pte;
            @(negedge clk);
        end
        bus.i_init_idx = 3'd5;
        bus.i_init_pte = mk_pte(0, 20'h55, 20'h77, 1, 0, 0);
        mdl[5] = bus.i_init_pte;
        @(negedge clk);
        bus.i_init_vld = 0;
        chk("init entries", bus.o_tlb_reg, mdl);

        for (int t = 0; t < 6; t++)
            do_miss(tbl[t].fetch, tbl[t].va, tbl[t].pte, tbl[t].dly, tbl[t].fault,
                    tbl[t].idx, tbl[t].addr, $sformatf("vec%0d", t));

        // Flush, fill invalid-first, then pointer evictions wrapping past 7.
        bus.i_flush = 1;
        @(negedge clk);
        bus.i_flush = 0;
        clear_valid();
        chk("flush entries", bus.o_tlb_reg, mdl);
        for (int k = 0; k < 17; k++) begin
            vpn = (k < 8) ? 20'(32'h100 + k) : 20'(32'h200 + k - 8);
            do_miss(1'b1, {vpn, 12'h000}, mk_pte(0, vpn, 20'(k), 1, 1, 0), k % 3, 1'b0,
                    (k < 8) ? k : (k - 8) % 8, {9'd0, vpn, 3'b000}, $sformatf("fill%0d", k));
        end

        // Both sides miss the same VPN: one walk, stale fetch miss ignored afterwards.
        bus.i_fetch_miss = 1; bus.i_fetch_va = 32'h0030_0000;
        bus.i_tlb_miss   = 1; bus.i_tlb_va   = 32'h0030_0000;
        @(negedge clk);
        chk("same mem_addr", {bus.o_mem_req, bus.o_mem_addr}, {1'b1, 32'h1800});
        p = mk_pte(0, 20'h300, 20'h33, 1, 1, 0);
        bus.i_mem_pte = p; bus.i_mem_ack = 1;
        @(negedge clk);
        bus.i_mem_ack = 0;
        @(negedge clk);
        chk("same done", {bus.o_tlb_done, bus.o_fetch_done}, 2'b10);
        mdl[1] = p;
        bus.i_tlb_miss = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("same no rewalk", {bus.o_busy, bus.o_mem_req}, 0);
        end
        bus.i_fetch_miss = 0;
        chk("same entries", bus.o_tlb_reg, mdl);

        // Flush and init while walking: fill lands, then flush, then init.
        bus.i_fetch_miss = 1; bus.i_fetch_va = 32'h0040_0000;
        @(negedge clk);
        chk("fw mem_addr", {bus.o_mem_req, bus.o_mem_addr}, {1'b1, 32'h2000});
        x = mk_pte(1, 20'h66, 20'hABC, 1, 1, 1);
        bus.i_flush = 1; bus.i_init_vld = 1; bus.i_init_idx = 3'd6; bus.i_init_pte = x;
        @(negedge clk);
        bus.i_flush = 0; bus.i_init_vld = 0;
        chk("fw still walking", bus.o_mem_req, 1);
        p = mk_pte(0, 20'h400, 20'h44, 1, 1, 0);
        bus.i_mem_pte = p; bus.i_mem_ack = 1;
        @(negedge clk);
        bus.i_mem_ack = 0;
        @(negedge clk);
        mdl[2] = p;
        chk("fw done", bus.o_fetch_done, 1);
        chk("fw filled", bus.o_tlb_reg, mdl);
        bus.i_fetch_miss = 0;
        @(negedge clk);
        chk("fw idle", bus.o_busy, 0);
        @(negedge clk);
        clear_valid();
        mdl[6] = x;
        chk("fw flushed", bus.o_tlb_reg, mdl);
`ifdef TLB_REFILL_STATS_EN
        chk("walk_cnt", bus.o_walk_cnt, 27);
        chk("fault_cnt", bus.o_fault_cnt, 2);
`endif

        // Reset in the middle of a walk; a late ack must be ignored.
        bus.i_tlb_miss = 1; bus.i_tlb_va = 32'h0050_0000;
        @(negedge clk);
        chk("rw mem_req", bus.o_mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw req dropped", {bus.o_mem_req, bus.o_busy}, 0);
        chk("rw entries", bus.o_tlb_reg, 0);
        bus.i_tlb_miss = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_mem_pte = mk_pte(0, 20'h500, 20'h55, 1, 1, 0);
        bus.i_mem_ack = 1;
        @(negedge clk);
        bus.i_mem_ack = 0;
        @(negedge clk);
        chk("late ack ignored", {bus.o_busy, bus.o_mem_req, bus.o_fetch_done, bus.o_tlb_done}, 0);
        chk("late ack entries", bus.o_tlb_reg, 0);
`ifdef TLB_REFILL_STATS_EN
        chk("walk_cnt reset", bus.o_walk_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
